// File: rtl/ad9226_capture.sv
// ad9226_capture: AD9226 sample-clock generator with a triggered, circular-buffer frame capture.
// Keeps PRETRIG samples ahead of a hysteretic level trigger and reads the frame out trigger-aligned.
module ad9226_capture #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 10,
  parameter int PRETRIG = 256,
  parameter int DIV     = 2,
  parameter int HYST    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              adc_clk,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic              force_trig,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PH_W  = $clog2(DIV);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]   PH_HALF  = PH_W'(DIV / 2);
  localparam logic [PH_W-1:0]   PH_ONE   = PH_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PRE_CNT  = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] POST_CNT = ADDR_W'(DEPTH - PRETRIG);
  localparam logic [ADDR_W-1:0] LAST_RD  = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W:0]   HYST_EXT = (DATA_W + 1)'(HYST);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_READ = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] sat_lo(input logic [DATA_W-1:0] lvl);
    logic [DATA_W:0] diff;
    diff = {1'b0, lvl} - HYST_EXT;
    return diff[DATA_W] ? {DATA_W{1'b0}} : diff[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_hi(input logic [DATA_W-1:0] lvl);
    logic [DATA_W:0] sum;
    sum = {1'b0, lvl} + HYST_EXT;
    return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
  endfunction

  state_t              state_r, state_s;
  logic [PH_W-1:0]     ph_r;
  logic                adc_clk_r, s_en_s;
  logic [DATA_W-1:0]   smp_r, level_r, lo_s, hi_s;
  logic                edge_r, rearm_r, rearm_set_s, trig_hit_s, fire_s;
  logic [ADDR_W-1:0]   wp_r, cnt_r, rp_r, rcnt_r;
  logic                write_s, start_s, rd_go_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DATA_W-1:0]   rd_data_r;
  logic                rd_valid_r, rd_last_r, busy_r, done_r;

  assign s_en_s      = (ph_r == PH_LAST);
  assign lo_s        = sat_lo(level_r);
  assign hi_s        = sat_hi(level_r);
  assign rearm_set_s = edge_r ? (smp_r > hi_s) : (smp_r < lo_s);
  assign trig_hit_s  = rearm_r && (edge_r ? (smp_r <= level_r) : (smp_r >= level_r));
  assign write_s     = s_en_s && ((state_r == ST_PRE) || (state_r == ST_WAIT) || (state_r == ST_POST));
  assign start_s     = arm && ((state_r == ST_IDLE) || (state_r == ST_READ));

  // Next-state logic; arm in READ abandons the readout and restarts the capture.
  always_comb begin
    state_s = state_r;
    fire_s  = 1'b0;
    rd_go_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arm) state_s = ST_PRE;
        else     state_s = ST_IDLE;
      end
      ST_PRE: begin
        if (s_en_s && ((cnt_r + ADDR_ONE) == PRE_CNT)) state_s = ST_WAIT;
        else                                            state_s = ST_PRE;
      end
      ST_WAIT: begin
        fire_s = s_en_s && (force_trig || trig_hit_s);
        if (fire_s) state_s = ST_POST;
        else        state_s = ST_WAIT;
      end
      ST_POST: begin
        if (s_en_s && ((cnt_r + ADDR_ONE) == POST_CNT)) state_s = ST_READ;
        else                                             state_s = ST_POST;
      end
      ST_READ: begin
        rd_go_s = rd_en && !arm;
        if (arm)                           state_s = ST_PRE;
        else if (rd_go_s && rcnt_r == LAST_RD) state_s = ST_IDLE;
        else                               state_s = ST_READ;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_PRE) || (state_s == ST_WAIT) || (state_s == ST_POST);
      done_r  <= (state_s == ST_READ);
    end
  end

  // Sample-period phase, ADC clock and input sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_r      <= {PH_W{1'b0}};
      adc_clk_r <= 1'b0;
      smp_r     <= {DATA_W{1'b0}};
    end else begin
      ph_r      <= s_en_s ? {PH_W{1'b0}} : ph_r + PH_ONE;
      adc_clk_r <= (ph_r < PH_HALF);
      if (s_en_s) smp_r <= adc_data;
    end
  end

  // Capture pointers, counters, trigger arming and latched trigger settings.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r    <= {ADDR_W{1'b0}};
      cnt_r   <= {ADDR_W{1'b0}};
      rp_r    <= {ADDR_W{1'b0}};
      rcnt_r  <= {ADDR_W{1'b0}};
      rearm_r <= 1'b0;
      level_r <= {DATA_W{1'b0}};
      edge_r  <= 1'b0;
    end else if (start_s) begin
      wp_r    <= {ADDR_W{1'b0}};
      cnt_r   <= {ADDR_W{1'b0}};
      rcnt_r  <= {ADDR_W{1'b0}};
      rearm_r <= 1'b0;
      level_r <= trig_level;
      edge_r  <= trig_edge;
    end else if (write_s) begin
      wp_r <= wp_r + ADDR_ONE;
      case (state_r)
        ST_WAIT: begin
          // Frame starts PRETRIG writes before the trigger sample's address.
          if (fire_s) begin
            cnt_r <= ADDR_ONE;
            rp_r  <= wp_r - PRE_CNT;
          end else if (rearm_set_s) begin
            rearm_r <= 1'b1;
          end else begin
            rearm_r <= rearm_r;
          end
        end
        ST_PRE, ST_POST: cnt_r <= cnt_r + ADDR_ONE;
        default:         cnt_r <= cnt_r;
      endcase
    end else if (rd_go_s) begin
      rp_r   <= rp_r + ADDR_ONE;
      rcnt_r <= rcnt_r + ADDR_ONE;
    end else begin
      rp_r <= rp_r;
    end
  end

  // Sample buffer write port.
  always_ff @(posedge clk) begin
    if (write_s) mem_r[wp_r] <= smp_r;
  end

  // Registered read port: one-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_go_s;
      rd_last_r  <= rd_go_s && (rcnt_r == LAST_RD);
      if (rd_go_s) rd_data_r <= mem_r[rp_r];
    end
  end

  assign adc_clk  = adc_clk_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign rd_last  = rd_last_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_ad9226_capture.sv
// Bench for ad9226_capture: drives sample streams, predicts trigger index and frame contents
// from the written-sample sequence, and checks capture status and readout.
module tb_ad9226_capture;

  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int PRETRIG = 4;
  localparam int DIV     = 2;
  localparam int HYST    = 16;
  localparam int MAXV    = 4095;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              adc_clk;
  logic [DATA_W-1:0] adc_data = 12'd0;
  logic              arm = 1'b0;
  logic              force_trig = 1'b0;
  logic              trig_edge = 1'b0;
  logic [DATA_W-1:0] trig_level = 12'd0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_last, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic rst_q;

  // seq[j] is the value the buffer receives on capture write j; seq[0] is the pre-arm sample.
  int seq[$];
  bit fseq[$];
  int lvl;
  bit edg;
  int frame[DEPTH];

  ad9226_capture #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .DIV(DIV), .HYST(HYST)
  ) dut (
    .clk(clk), .rst(rst), .adc_clk(adc_clk), .adc_data(adc_data), .arm(arm),
    .force_trig(force_trig), .trig_edge(trig_edge), .trig_level(trig_level),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle count since reset release, used to find sample-period boundaries.
  always @(posedge clk) begin
    rst_q <= rst;
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ADC clock: high for the first DIV/2 cycles of every sample period.
  always @(negedge clk) begin
    if (rst_q === 1'b1) check_val("adc_clk_rst", 32'(adc_clk), 32'd0);
    else if (rst_q === 1'b0) check_val("adc_clk", 32'(adc_clk), 32'(((cyc - 1) % DIV) < (DIV / 2)));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference trigger search over the written stream: hysteresis re-arm, level crossing, force.
  function automatic int find_trig();
    int lo, hi;
    bit armed;
    lo = (lvl - HYST < 0) ? 0 : lvl - HYST;
    hi = (lvl + HYST > MAXV) ? MAXV : lvl + HYST;
    armed = 1'b0;
    for (int j = PRETRIG; j < seq.size(); j++) begin
      if (fseq[j]) return j;
      if (!edg && armed && seq[j] >= lvl) return j;
      if (edg && armed && seq[j] <= lvl) return j;
      if (!edg && seq[j] < lo) armed = 1'b1;
      if (edg && seq[j] > hi) armed = 1'b1;
    end
    return -1;
  endfunction

  task automatic align();
    while ((cyc % DIV) != 0) @(negedge clk);
  endtask

  task automatic put_sample(input int v, input bit a, input bit f);
    adc_data = 12'(v);
    arm = a;
    force_trig = f;
    for (int i = 0; i < DIV; i++) begin
      @(negedge clk);
      arm = 1'b0;
    end
    force_trig = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; force_trig = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_val("rst_rd_last", 32'(rd_last), 32'd0);
    check_val("rst_rd_data", 32'(rd_data), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    idle_rd_check();
  endtask

  task automatic idle_rd_check();
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      check_val("idle_rd_valid", 32'(rd_valid), 32'd0);
      check_val("idle_done", 32'(done), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
    end
    rd_en = 1'b0;
  endtask

  task automatic build_rand(input int n, input int force_j);
    seq.delete(); fseq.delete();
    for (int j = 0; j < n; j++) begin
      seq.push_back(int'($urandom_range(0, MAXV)));
      fseq.push_back(1'b0);
    end
    fseq[force_j] = 1'b1;
    fseq[1] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_capture(input int arm2_j, input int rst_j, input bit scramble_level);
    int t, jend;
    t = find_trig();
    if (t < 0) begin
      check_val("model_trigger", 32'd0, 32'd1);
      return;
    end
    jend = t + DEPTH - PRETRIG - 1;
    while (seq.size() < jend + 2) begin
      seq.push_back(int'($urandom_range(0, MAXV)));
      fseq.push_back(1'b0);
    end
    align();
    trig_level = 12'(lvl);
    trig_edge = edg;
    put_sample(seq[0], 1'b0, 1'b0);
    for (int j = 0; j <= jend; j++) begin
      put_sample(seq[j + 1], (j == 0) || (j == arm2_j), fseq[j]);
      if (j == rst_j) begin
        do_reset();
        return;
      end
      if (scramble_level && j == 0) begin
        trig_level = 12'($urandom_range(0, MAXV));
        trig_edge = ~edg;
      end
      check_val("busy", 32'(busy), 32'(j < jend));
      check_val("done", 32'(done), 32'(j == jend));
    end
    for (int i = 0; i < DEPTH; i++) frame[i] = seq[t - PRETRIG + i];
  endtask

  // mode 0: back-to-back, 1: random gaps, 2: idle, gapped, then back-to-back.
  task automatic read_frame(input int mode, input int stop_at);
    int i, guard;
    bit en;
    i = 0; guard = 0;
    if (mode == 2) begin
      rd_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check_val("rd_idle_valid", 32'(rd_valid), 32'd0);
        check_val("rd_idle_done", 32'(done), 32'd1);
      end
    end
    while (i < stop_at && guard < 400) begin
      guard++;
      case (mode)
        0:       en = 1'b1;
        1:       en = ($urandom_range(0, 2) != 0);
        default: en = (i >= 8) || (guard % 2 == 0);
      endcase
      rd_en = en;
      @(negedge clk);
      check_val("rd_valid", 32'(rd_valid), 32'(en));
      if (en) begin
        check_val("rd_data", 32'(rd_data), 32'(frame[i]));
        check_val("rd_last", 32'(rd_last), 32'(i == DEPTH - 1));
        i++;
      end
      check_val("done_rd", 32'(done), 32'(i < DEPTH));
    end
    rd_en = 1'b0;
  endtask

  initial begin
    do_reset();

    // Rising ramp: trigger on 2100, frame starts at 1700.
    seq.delete(); fseq.delete();
    for (int j = 0; j < 41; j++) begin seq.push_back(100 * j); fseq.push_back(1'b0); end
    lvl = 2048; edg = 1'b0;
    run_capture(-1, -1, 1'b0);
    read_frame(2, DEPTH);
    idle_rd_check();

    // Hysteresis: 2040 never re-arms, the dip to 2000 does.
    seq.delete(); fseq.delete();
    for (int j = 0; j < 13; j++) begin seq.push_back(2040); fseq.push_back(1'b0); end
    for (int j = 0; j < 5; j++)  begin seq.push_back(2100); fseq.push_back(1'b0); end
    seq.push_back(2000); fseq.push_back(1'b0);
    for (int j = 0; j < 21; j++) begin seq.push_back(2100); fseq.push_back(1'b0); end
    lvl = 2048; edg = 1'b0;
    run_capture(-1, -1, 1'b0);
    read_frame(0, DEPTH);

    // Falling edge near full scale: hi saturates, only force_trig can end the wait.
    build_rand(40, 30);
    lvl = 4090; edg = 1'b1;
    run_capture(-1, -1, 1'b0);
    read_frame(1, DEPTH);

    // Long wait with a counting pattern so the buffer wraps before the forced trigger.
    seq.delete(); fseq.delete();
    for (int j = 0; j < 60; j++) begin seq.push_back(10 * j); fseq.push_back(1'b0); end
    fseq[PRETRIG + 40] = 1'b1;
    lvl = MAXV; edg = 1'b0;
    run_capture(-1, -1, 1'b0);
    read_frame(0, DEPTH);

    // Random captures; the last readout is abandoned at read 7 by the next arm.
    for (int k = 0; k < 4; k++) begin
      build_rand(50, int'($urandom_range(PRETRIG, 45)));
      lvl = int'($urandom_range(64, MAXV - 64));
      edg = 1'($urandom_range(0, 1));
      run_capture(int'($urandom_range(1, PRETRIG + 1)), -1, 1'b1);
      read_frame(k % 3, (k == 3) ? 7 : DEPTH);
    end
    build_rand(50, int'($urandom_range(PRETRIG, 45)));
    lvl = int'($urandom_range(64, MAXV - 64));
    edg = 1'($urandom_range(0, 1));
    run_capture(-1, -1, 1'b0);
    read_frame(0, DEPTH);

    // Reset in POST, then a normal capture to show recovery.
    build_rand(30, PRETRIG);
    lvl = 2048; edg = 1'b0;
    run_capture(-1, PRETRIG + 3, 1'b0);
    build_rand(50, 40);
    lvl = int'($urandom_range(64, MAXV - 64));
    edg = 1'($urandom_range(0, 1));
    run_capture(-1, -1, 1'b0);
    read_frame(1, DEPTH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
